// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path.
// State codes, parity modes and accumulator width.
package uart_pkg;

  localparam int ACC_W = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional baud accumulator: one tick per bit period,
// exact long-term rate for any integer MHz clock.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int FMAX_MHz  = 27,
  parameter int BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam longint F_L = longint'(FMAX_MHz) * 1000000;

  localparam logic [ACC_W:0] F_HZ =
    (ACC_W+1)'(F_L);
  localparam logic [ACC_W:0] STEP =
    (ACC_W+1)'(BAUD_RATE);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic             wrap;

  // One extra bit keeps acc+BAUD_RATE from overflowing.
  assign sum  = {1'b0, acc} + STEP;
  assign wrap = (sum >= F_HZ);
  assign tick = enable & wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      if (wrap) acc <= ACC_W'(sum - F_HZ);
      else      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start, LSB-first data,
// optional parity, stop bits; registered line output.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int FMAX_MHz  = 27,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       uart_tx
);

  localparam logic [7:0] DMASK =
    8'((16'd1 << DATA_BITS) - 16'd1);
  localparam logic [2:0] LAST_BIT =
    3'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic HAS_PAR = (PARITY != PARITY_NONE);
  localparam logic ODD_PAR = (PARITY == PARITY_ODD);

  logic [2:0] state;
  logic [7:0] sh;
  logic [2:0] bit_idx;
  logic       stop_cnt;
  logic       par;
  logic       tick;
  logic       accept;
  logic [7:0] masked;

  assign accept = (state == ST_IDLE) & ready & start;
  assign masked = data & DMASK;

  uart_baud_tick #(
    .FMAX_MHz (FMAX_MHz),
    .BAUD_RATE(BAUD_RATE)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .enable(state != ST_IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sh       <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
      uart_tx  <= 1'b1;
      ready    <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            sh      <= masked;
            par     <= (^masked) ^ ODD_PAR;
            bit_idx <= '0;
            uart_tx <= 1'b0;
            ready   <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            uart_tx <= sh[0];
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              stop_cnt <= 1'b0;
              if (HAS_PAR) begin
                uart_tx <= par;
                state   <= ST_PARITY;
              end else begin
                uart_tx <= 1'b1;
                state   <= ST_STOP;
              end
            end else begin
              sh      <= {1'b0, sh[7:1]};
              uart_tx <= sh[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            stop_cnt <= 1'b0;
            uart_tx  <= 1'b1;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_cnt == STOP_LAST) begin
              state <= ST_IDLE;
              ready <= 1'b1;
              done  <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
